esp32_spi_reg_ctrl: RTL and testbench

Command sequencer between the byte-level ESP32 SPI slave and the internal 8-bit register bus. It parses SPI frames into register read and write commands and issues them on a request/acknowledge bus with address auto-increment. It returns read data to the slave's transmit byte for the next frame, and tracks overrun, timeout and transfer-count status. Sits in the `clk_sys` domain, directly after the SPI slave's `rx_data`/`rx_valid`/`busy` outputs.

---
 rtl/esp32_spi_reg_ctrl_if.sv | 27 ++
 rtl/esp32_spi_reg_ctrl.sv | 121 ++++++++++++
 tb/tb_esp32_spi_reg_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/esp32_spi_reg_ctrl_if.sv
// Register-bus handshake between the SPI command sequencer (master) and the register file (slave).
interface esp32_spi_reg_ctrl_if;
  logic       bus_req;
  logic       bus_we;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/esp32_spi_reg_ctrl.sv
// Parses SPI frames into register read/write transactions with address auto-increment,
// a one-byte holding buffer, timeout handling and sticky error status.
module esp32_spi_reg_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 spi_busy,
  output logic [7:0]           tx_data,
  esp32_spi_reg_ctrl_if.master bus,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic [COUNT_W-1:0]   xfer_count
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StWrite, StReadIssue, StWaitAck, StDrain
  } state_e;

  state_e            state_q;
  logic              busy_q;
  logic [6:0]        ptr_q;
  logic [7:0]        buf_q;
  logic              buf_full_q;
  logic [7:0]        resp_q;
  logic [TimerW-1:0] timer_q;
  logic              timed_out;

  // Compared against TIMEOUT-1 so bus_req stays high for exactly TIMEOUT cycles.
  assign timed_out = (timer_q == TimerW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      ptr_q         <= 7'h00;
      buf_q         <= 8'h00;
      buf_full_q    <= 1'b0;
      resp_q        <= 8'h00;
      timer_q       <= '0;
      tx_data       <= 8'h00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 7'h00;
      bus.bus_wdata <= 8'h00;
      err_overrun   <= 1'b0;
      err_timeout   <= 1'b0;
      xfer_count    <= '0;
    end else begin
      busy_q <= spi_busy;
      // The slave's shift register only reloads between frames.
      if (!spi_busy) tx_data <= resp_q;

      unique case (state_q)
        StIdle: begin
          if (spi_busy && !busy_q) state_q <= StCmd;
        end
        StCmd: begin
          if (rx_valid) begin
            ptr_q   <= rx_data[6:0];
            state_q <= rx_data[7] ? StWrite : StReadIssue;
          end else if (!spi_busy) begin
            state_q <= StIdle;
          end
        end
        StWrite: begin
          if (buf_full_q || rx_valid) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= 1'b1;
            bus.bus_addr  <= ptr_q;
            bus.bus_wdata <= buf_full_q ? buf_q : rx_data;
            ptr_q         <= ptr_q + 7'd1;
            timer_q       <= '0;
            state_q       <= StWaitAck;
            // Draining the buffer while a new byte lands refills it in the same cycle.
            if (buf_full_q && rx_valid) buf_q <= rx_data;
            else buf_full_q <= 1'b0;
          end else if (!spi_busy) begin
            state_q <= StIdle;
          end
        end
        StReadIssue: begin
          bus.bus_req  <= 1'b1;
          bus.bus_we   <= 1'b0;
          bus.bus_addr <= ptr_q;
          timer_q      <= '0;
          state_q      <= StWaitAck;
        end
        StWaitAck: begin
          if (bus.bus_we && rx_valid) begin
            if (buf_full_q) begin
              err_overrun <= 1'b1;
            end else begin
              buf_q      <= rx_data;
              buf_full_q <= 1'b1;
            end
          end
          if (bus.bus_ack || timed_out) begin
            bus.bus_req <= 1'b0;
            xfer_count  <= xfer_count + COUNT_W'(1);
            if (!bus.bus_ack) err_timeout <= 1'b1;
            if (!bus.bus_we) resp_q <= bus.bus_ack ? bus.bus_rdata : 8'hEE;
            state_q <= bus.bus_we ? StWrite : StDrain;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StDrain: begin
          if (!spi_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_esp32_spi_reg_ctrl.sv
// Scoreboard bench: a frame-level model queues expected bus transactions, a monitor checks them.
module tb_esp32_spi_reg_ctrl;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        spi_busy;
  logic [7:0]  tx_data;
  logic        err_overrun;
  logic        err_timeout;
  logic [15:0] xfer_count;

  esp32_spi_reg_ctrl_if bif ();

  esp32_spi_reg_ctrl #(
    .TIMEOUT (255),
    .COUNT_W (16)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .spi_busy    (spi_busy),
    .tx_data     (tx_data),
    .bus         (bif),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .xfer_count  (xfer_count)
  );

  initial forever #10 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_err = 0;
  txn_t        exp_q[$];
  int          ack_delay = 3;   // negative: never acknowledge
  logic [7:0]  rdata_next = 8'h00;
  int          last_len = 0;
  int          exp_xfer = 0;
  logic [7:0]  exp_tx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Frame-level reference: what a frame should do to the register bus, ignoring timing.
  task automatic model_frame(input bq_t fr, input bit acked);
    logic [6:0] ptr;
    txn_t       t;
    ptr = fr[0][6:0];
    if (fr[0][7]) begin
      for (int i = 1; i < fr.size(); i++) begin
        t = '{we: 1'b1, addr: ptr, wdata: fr[i]};
        exp_q.push_back(t);
        ptr = 7'((int'(ptr) + 1) % 128);
        exp_xfer++;
      end
    end else begin
      t = '{we: 1'b0, addr: ptr, wdata: 8'h00};
      exp_q.push_back(t);
      exp_xfer++;
      exp_tx = acked ? rdata_next : 8'hEE;
    end
  endtask

  task automatic send_frame(input bq_t fr, input int gap);
    logic [7:0] tx0;
    logic [7:0] tx_bad;
    spi_busy = 1'b1;
    @(negedge clk_sys);
    tx0 = tx_data;
    tx_bad = tx0;
    repeat (3) begin
      @(negedge clk_sys);
      if (tx_data !== tx0) tx_bad = tx_data;
    end
    foreach (fr[i]) begin
      rx_data  = fr[i];
      rx_valid = 1'b1;
      @(negedge clk_sys);
      rx_valid = 1'b0;
      if (tx_data !== tx0) tx_bad = tx_data;
      repeat (gap - 1) begin
        @(negedge clk_sys);
        if (tx_data !== tx0) tx_bad = tx_data;
      end
    end
    spi_busy = 1'b0;
    check("tx_stable_in_frame", tx_bad, tx0);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int k = 0;
    while (quiet < 8 && k < 3000) begin
      @(negedge clk_sys);
      k++;
      if (!bif.bus_req && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle: got %0d pending txns, required 0 within 3000 cycles", exp_q.size());
    end
  endtask

  initial begin : responder
    int cnt = 0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 8'h00;
    forever begin
      @(negedge clk_sys);
      bif.bus_ack = 1'b0;
      if (!bif.bus_req) begin
        cnt = 0;
      end else if (ack_delay >= 0) begin
        if (cnt == ack_delay) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = rdata_next;
        end
        cnt++;
      end
    end
  end

  initial begin : monitor
    logic prev = 1'b0;
    int   len = 0;
    txn_t e;
    forever begin
      @(negedge clk_sys);
      if (bif.bus_req) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_req: got we=%0b addr=%0h wdata=%0h, required none",
                     bif.bus_we, bif.bus_addr, bif.bus_wdata);
          end else begin
            e = exp_q.pop_front();
            check("req_we", bif.bus_we, e.we);
            check("req_addr", bif.bus_addr, e.addr);
            if (e.we) check("req_wdata", bif.bus_wdata, e.wdata);
          end
        end
        len++;
      end else if (prev) begin
        last_len = len;
        len = 0;
      end
      prev = bif.bus_req;
    end
  end

  initial begin : stimulus
    bq_t fr;
    int  k;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    spi_busy = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_tx", tx_data, 8'h00);
    check("rst_req", bif.bus_req, 1'b0);
    check("rst_addr", bif.bus_addr, 7'h00);
    check("rst_xfer", xfer_count, 16'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Write burst
    ack_delay = 3;
    fr = '{8'h85, 8'h11, 8'h22};
    model_frame(fr, 1'b1);
    send_frame(fr, 12);
    wait_idle();
    check("burst_xfer", xfer_count, 16'(exp_xfer));
    check("burst_tx", tx_data, 8'h00);

    // Read, result visible after the frame and stable through the next one
    rdata_next = 8'h11;
    fr = '{8'h05};
    model_frame(fr, 1'b1);
    send_frame(fr, 12);
    wait_idle();
    check("read_tx", tx_data, 8'h11);

    // Address wrap
    fr = '{8'hFF, 8'hAA, 8'hBB};
    model_frame(fr, 1'b1);
    send_frame(fr, 12);
    wait_idle();
    check("wrap_xfer", xfer_count, 16'(exp_xfer));

    // Random frames
    for (int f = 0; f < 20; f++) begin
      fr = {};
      fr.push_back(8'($urandom));
      k = $urandom_range(0, 4);
      for (int i = 0; i < k; i++) fr.push_back(8'($urandom));
      ack_delay  = $urandom_range(0, 5);
      rdata_next = 8'($urandom);
      model_frame(fr, 1'b1);
      send_frame(fr, 12);
      wait_idle();
      check("rand_xfer", xfer_count, 16'(exp_xfer));
      check("rand_tx", tx_data, exp_tx);
    end
    check("rand_no_err", {err_overrun, err_timeout}, 2'b00);

    // Overrun: third byte arrives while one is in flight and one is buffered
    ack_delay = 200;
    exp_q.push_back('{we: 1'b1, addr: 7'h00, wdata: 8'h31});
    exp_q.push_back('{we: 1'b1, addr: 7'h01, wdata: 8'h32});
    exp_xfer += 2;
    fr = '{8'h80, 8'h31, 8'h32, 8'h33};
    send_frame(fr, 40);
    wait_idle();
    check("ovr_flag", err_overrun, 1'b1);
    check("ovr_xfer", xfer_count, 16'(exp_xfer));
    check("ovr_no_timeout", err_timeout, 1'b0);

    // Timeout on a read
    ack_delay = -1;
    fr = '{8'h10};
    model_frame(fr, 1'b0);
    send_frame(fr, 12);
    wait_idle();
    check("to_req_len", last_len, 255);
    check("to_flag", err_timeout, 1'b1);
    check("to_tx", tx_data, 8'hEE);
    check("to_xfer", xfer_count, 16'(exp_xfer));
    check("to_ovr_sticky", err_overrun, 1'b1);

    // Reset while waiting for an ack
    fr = '{8'h81, 8'h42};
    model_frame(fr, 1'b1);
    spi_busy = 1'b1;
    repeat (3) @(negedge clk_sys);
    foreach (fr[i]) begin
      rx_data  = fr[i];
      rx_valid = 1'b1;
      @(negedge clk_sys);
      rx_valid = 1'b0;
      repeat (5) @(negedge clk_sys);
    end
    k = 0;
    while (!bif.bus_req && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    check("rst_mid_req_seen", bif.bus_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_req", bif.bus_req, 1'b0);
    check("rst_mid_we", bif.bus_we, 1'b0);
    check("rst_mid_addr", bif.bus_addr, 7'h00);
    check("rst_mid_wdata", bif.bus_wdata, 8'h00);
    check("rst_mid_tx", tx_data, 8'h00);
    check("rst_mid_err", {err_overrun, err_timeout}, 2'b00);
    check("rst_mid_xfer", xfer_count, 16'h0);
    exp_xfer = 0;
    exp_tx   = 8'h00;
    spi_busy = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    repeat (3) @(negedge clk_sys);
    ack_delay = 3;
    fr = '{8'h81, 8'h33};
    model_frame(fr, 1'b1);
    send_frame(fr, 12);
    wait_idle();
    check("post_rst_xfer", xfer_count, 16'(exp_xfer));
    check("post_rst_tx", tx_data, exp_tx);
    check("post_rst_err", {err_overrun, err_timeout}, 2'b00);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
